// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//
// Command sequencer for an external 8-bit, 3-bit-opcode ALU.
//
// It owns a 4 x DATA_W register file. It accepts one command at a time over a
// valid/ready handshake and drives the ALU operand and opcode ports from
// registers. One cycle later it captures the ALU result (or the immediate, for
// load commands), writes it back into the register file, and presents it on a
// valid/ready result port.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_ld                1 = load cmd_imm into cmd_rd, 0 = ALU operation
//   cmd_op                ALU opcode, forwarded unchanged to alu_opc
//   cmd_rd/ra/rb          destination / operand-a / operand-b register index
//   cmd_imm               immediate for load commands
//   alu_opc/alu_a/alu_b   registered opcode and operands to the external ALU
//   alu_s                 combinational ALU result
//   res_valid/res_ready   result handshake
//   res_data/res_rd       written value and its destination index
//   res_zero              res_data == 0
//   op_count              results accepted by the consumer (wraps)
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ld,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_rd,
    input  logic [1:0]        cmd_ra,
    input  logic [1:0]        cmd_rb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [2:0]        alu_opc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_s,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [1:0]        res_rd,
    output logic              res_zero,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched command fields, needed when the result is written back.
    logic              ld_q, ld_d;
    logic [1:0]        rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    // Register file. It is reset asynchronously, so it is built from flops
    // rather than inferred RAM.
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] rf_d [4];

    logic [2:0]        alu_opc_q, alu_opc_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;

    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [1:0]        res_rd_q, res_rd_d;
    logic              res_zero_q, res_zero_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    // Value committed in EXEC: the immediate for loads, the settled ALU
    // output otherwise.
    logic [DATA_W-1:0] wb_value;

    assign wb_value = ld_q ? imm_q : alu_s;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ld_d        = ld_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        alu_opc_d   = alu_opc_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_zero_d  = res_zero_q;
        op_count_d  = op_count_q;
        for (int i = 0; i < 4; i++) begin
            rf_d[i] = rf_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ld_d  = cmd_ld;
                    rd_d  = cmd_rd;
                    imm_d = cmd_imm;
                    // A load leaves the ALU inputs untouched, so the ALU
                    // ports keep showing the last real operation.
                    if (!cmd_ld) begin
                        alu_opc_d = cmd_op;
                        alu_a_d   = rf_q[cmd_ra];
                        alu_b_d   = rf_q[cmd_rb];
                    end
                    state_d = EXEC;
                end
            end

            EXEC: begin
                // The operands were sampled at accept time. The write to rd
                // therefore never feeds back into this operation, even when
                // rd aliases ra or rb.
                rf_d[rd_q]  = wb_value;
                res_data_d  = wb_value;
                res_rd_d    = rd_q;
                res_zero_d  = (wb_value == '0);
                res_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_q        <= 1'b0;
            rd_q        <= 2'd0;
            imm_q       <= '0;
            alu_opc_q   <= 3'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= 2'd0;
            res_zero_q  <= 1'b0;
            op_count_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            alu_opc_q   <= alu_opc_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_zero_q  <= res_zero_d;
            op_count_q  <= op_count_d;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready = (state_q == IDLE);
    assign alu_opc   = alu_opc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign res_zero  = res_zero_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Directed bench for alu_seq_ctrl.
//
// Two instances share the command and result stimulus:
//   u_dut   uses the default CNT_W = 16.
//   u_dut4  uses CNT_W = 4, which exercises op_count wrap-around.
// Each instance drives its own behavioural ALU.
//
// Expected results come from a register-file model in the bench. They are
// pushed to a queue when a command is accepted, and popped when res_valid
// rises.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ld = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [1:0] cmd_rd = 2'd0;
    logic [1:0] cmd_ra = 2'd0;
    logic [1:0] cmd_rb = 2'd0;
    logic [7:0] cmd_imm = 8'd0;
    logic       res_ready = 1'b0;

    logic        cmd_ready, res_valid, res_zero;
    logic [2:0]  alu_opc;
    logic [7:0]  alu_a, alu_b, alu_s, res_data;
    logic [1:0]  res_rd;
    logic [15:0] op_count;

    logic        cmd_ready4, res_valid4, res_zero4;
    logic [2:0]  alu_opc4;
    logic [7:0]  alu_a4, alu_b4, alu_s4, res_data4;
    logic [1:0]  res_rd4;
    logic [3:0]  op_count4;

    always #5 clk = ~clk;

    // Behavioural model of the external ALU
    // (OR/AND/XOR/NOT-a/ADD/SUB/INC-a/INC-b).
    function automatic logic [7:0] alu_fn(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return a | b;
            3'd1:    return a & b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return a + 8'd1;
            default: return b + 8'd1;
        endcase
    endfunction

    assign alu_s  = alu_fn(alu_opc, alu_a, alu_b);
    assign alu_s4 = alu_fn(alu_opc4, alu_a4, alu_b4);

    alu_seq_ctrl #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ld(cmd_ld), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_imm(cmd_imm),
        .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rd(res_rd), .res_zero(res_zero),
        .op_count(op_count)
    );

    alu_seq_ctrl #(.DATA_W(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_ld(cmd_ld), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_imm(cmd_imm),
        .alu_opc(alu_opc4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_s(alu_s4),
        .res_valid(res_valid4), .res_ready(res_ready),
        .res_data(res_data4), .res_rd(res_rd4), .res_zero(res_zero4),
        .op_count(op_count4)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] rd;
        logic       zero;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mrf [4];
    logic [2:0] exp_opc;
    logic [7:0] exp_a, exp_b;
    int         exp_count;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
        exp_opc   = 3'd0;
        exp_a     = 8'h00;
        exp_b     = 8'h00;
        exp_count = 0;
    endtask

    // Issues one command and checks the whole transaction. Called and
    // returning on a negative clock edge. 'hold' = DONE cycles spent with
    // res_ready low while a competing command (load r3=0x77) is offered.
    task automatic issue(input string tag, input logic ld, input logic [2:0] op,
                         input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] imm,
                         input int hold);
        exp_t       e;
        logic [7:0] v;
        int         waited;
        cmd_valid = 1'b1;
        cmd_ld    = ld;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_imm   = imm;
        waited    = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            chk($sformatf("%s_accept_timeout", tag), 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (ld) begin
            v = imm;
        end else begin
            v       = alu_fn(op, mrf[ra], mrf[rb]);
            exp_opc = op;
            exp_a   = mrf[ra];
            exp_b   = mrf[rb];
        end
        mrf[rd] = v;
        e.data  = v;
        e.rd    = rd;
        e.zero  = (v == 8'h00);
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk($sformatf("%s_exec_valid", tag), 32'(res_valid), 32'd0);
        chk($sformatf("%s_exec_ready", tag), 32'(cmd_ready), 32'd0);
        chk($sformatf("%s_alu_opc", tag), 32'(alu_opc), 32'(exp_opc));
        chk($sformatf("%s_alu_a", tag), 32'(alu_a), 32'(exp_a));
        chk($sformatf("%s_alu_b", tag), 32'(alu_b), 32'(exp_b));
        @(negedge clk);
        chk($sformatf("%s_latency_valid", tag), 32'(res_valid), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_data", tag), 32'(res_data), 32'(e.data));
            chk($sformatf("%s_rd", tag), 32'(res_rd), 32'(e.rd));
            chk($sformatf("%s_zero", tag), 32'(res_zero), 32'(e.zero));
            chk($sformatf("%s_data4", tag), 32'(res_data4), 32'(e.data));
        end else begin
            chk($sformatf("%s_sb_empty", tag), 32'(sb.size()), 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_ld    = 1'b1;
            cmd_rd    = 2'd3;
            cmd_imm   = 8'h77;
            @(negedge clk);
            chk($sformatf("%s_hold%0d_valid", tag, i), 32'(res_valid), 32'd1);
            chk($sformatf("%s_hold%0d_data", tag, i), 32'(res_data), 32'(e.data));
            chk($sformatf("%s_hold%0d_ready", tag, i), 32'(cmd_ready), 32'd0);
            chk($sformatf("%s_hold%0d_count", tag, i), 32'(op_count), 32'(exp_count));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_count++;
        chk($sformatf("%s_count", tag), 32'(op_count), 32'(exp_count % 65536));
        chk($sformatf("%s_count4", tag), 32'(op_count4), 32'(exp_count % 16));
        chk($sformatf("%s_release_valid", tag), 32'(res_valid), 32'd0);
        chk($sformatf("%s_release_ready", tag), 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1;
        // Reset state while rst is held
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_alu_opc", 32'(alu_opc), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Loads followed by an ADD (8'h05 + 8'h03)
        issue("ld_r0", 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h05, 0);
        issue("ld_r1", 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h03, 0);
        issue("add_r2", 1'b0, 3'd4, 2'd2, 2'd0, 2'd1, 8'h00, 0);
        // SUB wrapping below zero, NOT with rd aliasing ra, then read back r0
        issue("sub_r3", 1'b0, 3'd5, 2'd3, 2'd1, 2'd0, 8'h00, 0);
        issue("not_r0", 1'b0, 3'd3, 2'd0, 2'd0, 2'd0, 8'h00, 0);
        issue("or_rd_r0", 1'b0, 3'd0, 2'd1, 2'd0, 2'd0, 8'h00, 0);
        // INC-a of 0xFF wraps to zero in place
        issue("ld_r1_ff", 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'hFF, 0);
        issue("inc_r1", 1'b0, 3'd6, 2'd1, 2'd1, 2'd0, 8'h00, 0);
        issue("inc_b", 1'b0, 3'd7, 2'd0, 2'd2, 2'd3, 8'h00, 0);
        issue("xor", 1'b0, 3'd2, 2'd0, 2'd2, 2'd3, 8'h00, 0);
        // Back-pressure in DONE with a competing command offered
        issue("and_bp", 1'b0, 3'd1, 2'd3, 2'd0, 2'd0, 8'h00, 4);
        issue("ld_r3_77", 1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 8'h77, 0);

        // Reset in the middle of EXEC drops the write back into r2
        cmd_valid = 1'b1;
        cmd_ld    = 1'b0;
        cmd_op    = 3'd4;
        cmd_rd    = 2'd2;
        cmd_ra    = 2'd0;
        cmd_rb    = 2'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_exec_valid", 32'(res_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res_data", 32'(res_data), 32'd0);
        chk("mid_rst_res_rd", 32'(res_rd), 32'd0);
        chk("mid_rst_res_zero", 32'(res_zero), 32'd0);
        chk("mid_rst_alu_opc", 32'(alu_opc), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("post_rst_valid", 32'(res_valid), 32'd0);

        // 16 completions wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            issue($sformatf("wrap%0d", i), 1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 8'(i * 17), 0);
        end
        chk("wrap_count4_zero", 32'(op_count4), 32'd0);
        chk("wrap_count16", 32'(op_count), 32'd16);

        // r2 must read zero after the reset
        issue("read_r2", 1'b0, 3'd0, 2'd0, 2'd2, 2'd2, 8'h00, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
